// File: rtl/multi_timer.sv
// Multi-channel prescaled down-counter timer on an 8-bit byte-addressed peripheral bus.
// Each channel: one-shot/auto-reload, sticky expiry flag, maskable interrupt.
module multi_timer #(
    parameter int MCLKFREQ = 24000000,
    parameter int TICKHZ   = 100,
    parameter int NCHAN    = 4,
    parameter int WIDTH    = 16,
    localparam int CHB     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [CHB+1:0] addr,
    input  logic [7:0]     di,
    input  logic           wren,
    input  logic           rden,
    output logic [7:0]     q,
    output logic           tick,
    output logic           irq
);
    localparam int DIV = MCLKFREQ / TICKHZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [7:0]       q_q, q_d;
    logic [WIDTH-1:0] count_q [NCHAN];
    logic [WIDTH-1:0] count_d [NCHAN];
    logic [WIDTH-1:0] reload_q [NCHAN];
    logic [WIDTH-1:0] reload_d [NCHAN];
    logic [7:0]       hold_q [NCHAN];
    logic [7:0]       hold_d [NCHAN];
    logic [7:0]       snap_q [NCHAN];
    logic [7:0]       snap_d [NCHAN];
    logic [2:0]       ctrl_q [NCHAN];
    logic [2:0]       ctrl_d [NCHAN];
    logic [NCHAN-1:0] flag_q, flag_d;

    logic [CHB-1:0]   chan;
    logic [1:0]       rsel;
    logic             sel, commit, set_now, irq_c;
    logic [15:0]      cnt16, wdata;
    logic [7:0]       flags_all;

    always_comb begin
        presc_d = (presc_q == '0) ? PW'(DIV - 1) : presc_q - PW'(1);
        tick_d  = (presc_q == '0);
    end

    always_comb begin
        chan      = addr[CHB+1:2];
        rsel      = addr[1:0];
        q_d       = q_q;
        count_d   = count_q;
        reload_d  = reload_q;
        hold_d    = hold_q;
        snap_d    = snap_q;
        ctrl_d    = ctrl_q;
        flag_d    = flag_q;
        sel       = 1'b0;
        commit    = 1'b0;
        set_now   = 1'b0;
        cnt16     = '0;
        wdata     = '0;
        flags_all = '0;
        for (int i = 0; i < NCHAN; i++) flags_all[i] = flag_q[i];

        // Out-of-range channels never match sel, so reads fall through to 0.
        if (rden) q_d = '0;

        for (int i = 0; i < NCHAN; i++) begin
            sel     = (chan == CHB'(i));
            commit  = wren && sel && (rsel == 2'd1);
            set_now = 1'b0;
            cnt16   = '0;
            cnt16[WIDTH-1:0] = count_q[i];
            wdata   = {di, hold_q[i]};

            if (tick_q && ctrl_q[i][0] && !commit) begin
                if (count_q[i] > WIDTH'(1)) begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end else if (count_q[i] == WIDTH'(1)) begin
                    set_now    = 1'b1;
                    flag_d[i]  = 1'b1;
                    count_d[i] = (ctrl_q[i][1] && reload_q[i] != '0) ? reload_q[i] : '0;
                end
            end

            if (wren && sel) begin
                case (rsel)
                    2'd0: hold_d[i] = di;
                    2'd1: begin
                        reload_d[i] = wdata[WIDTH-1:0];
                        count_d[i]  = wdata[WIDTH-1:0];
                    end
                    2'd2: begin
                        ctrl_d[i] = di[2:0];
                        if (di[7] && !set_now) flag_d[i] = 1'b0;
                    end
                    default: ;
                endcase
            end

            if (rden && sel) begin
                case (rsel)
                    2'd0: begin
                        q_d       = cnt16[7:0];
                        snap_d[i] = cnt16[15:8];
                    end
                    2'd1:    q_d = snap_q[i];
                    2'd2:    q_d = {flag_q[i], 4'b0000, ctrl_q[i]};
                    default: q_d = flags_all;
                endcase
            end
        end
    end

    always_comb begin
        irq_c = 1'b0;
        for (int i = 0; i < NCHAN; i++) irq_c = irq_c | (flag_q[i] & ctrl_q[i][2]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= PW'(DIV - 1);
            tick_q   <= 1'b0;
            q_q      <= '0;
            count_q  <= '{default: '0};
            reload_q <= '{default: '0};
            hold_q   <= '{default: '0};
            snap_q   <= '{default: '0};
            ctrl_q   <= '{default: '0};
            flag_q   <= '0;
        end else begin
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            q_q      <= q_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            hold_q   <= hold_d;
            snap_q   <= snap_d;
            ctrl_q   <= ctrl_d;
            flag_q   <= flag_d;
        end
    end

    assign q    = q_q;
    assign tick = tick_q;
    assign irq  = irq_c;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus random bus traffic checked
// against an integer-level reference model of the register/tick rules.
module tb_multi_timer;
    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] addr = '0;
    logic [7:0] di = '0;
    logic       wren = 1'b0, rden = 1'b0;
    logic [7:0] q;
    logic       tick, irq;

    logic [3:0] addr_b = '0;
    logic [7:0] di_b = '0;
    logic       wren_b = 1'b0, rden_b = 1'b0;
    logic [7:0] q_b;
    logic       tick_b, irq_b;

    multi_timer #(.MCLKFREQ(1000), .TICKHZ(100), .NCHAN(4), .WIDTH(16)) dut (
        .clk(clk), .reset(reset), .addr(addr), .di(di), .wren(wren), .rden(rden),
        .q(q), .tick(tick), .irq(irq)
    );

    multi_timer #(.MCLKFREQ(1000), .TICKHZ(100), .NCHAN(3), .WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .addr(addr_b), .di(di_b), .wren(wren_b), .rden(rden_b),
        .q(q_b), .tick(tick_b), .irq(irq_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int tick_seen = 0;

    int m_cnt[4], m_rld[4], m_hold[4], m_snap[4], m_ctl[4], m_flg[4];
    int m_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, ncyc);
        end
    endtask

    function automatic int m_irq();
        int r = 0;
        for (int i = 0; i < 4; i++) if (m_flg[i] != 0 && (m_ctl[i] & 4) != 0) r = 1;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_rld[i] = 0; m_hold[i] = 0;
            m_snap[i] = 0; m_ctl[i] = 0; m_flg[i] = 0;
        end
        m_q = 0;
    endtask

    // Applies one clock edge worth of behaviour using the inputs currently driven.
    task automatic model_step();
        int ch, r, bm;
        int o_cnt[4], o_ctl[4], o_flg[4], o_snap[4], set_now[4];
        bit tk, cm;
        ch = int'(addr[3:2]);
        r  = int'(addr[1:0]);
        tk = (ncyc > 0) && (ncyc % DIV == 0);
        bm = 0;
        for (int i = 0; i < 4; i++) begin
            o_cnt[i] = m_cnt[i]; o_ctl[i] = m_ctl[i];
            o_flg[i] = m_flg[i]; o_snap[i] = m_snap[i];
            set_now[i] = 0;
            if (m_flg[i] != 0) bm += (1 << i);
        end
        if (rden) begin
            case (r)
                0: begin m_q = o_cnt[ch] % 256; m_snap[ch] = o_cnt[ch] / 256; end
                1: m_q = o_snap[ch];
                2: m_q = o_flg[ch] * 128 + o_ctl[ch];
                default: m_q = bm;
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            cm = wren && (ch == i) && (r == 1);
            if (tk && (o_ctl[i] & 1) != 0 && !cm) begin
                if (o_cnt[i] > 1) m_cnt[i] = o_cnt[i] - 1;
                else if (o_cnt[i] == 1) begin
                    m_flg[i] = 1;
                    set_now[i] = 1;
                    m_cnt[i] = ((o_ctl[i] & 2) != 0 && m_rld[i] != 0) ? m_rld[i] : 0;
                end
            end
        end
        if (wren) begin
            case (r)
                0: m_hold[ch] = int'(di);
                1: begin m_rld[ch] = int'(di) * 256 + m_hold[ch]; m_cnt[ch] = m_rld[ch]; end
                2: begin
                    m_ctl[ch] = int'(di) & 7;
                    if (di[7] && set_now[ch] == 0) m_flg[ch] = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        ncyc++;
        #1;
        if (tick === 1'b1) tick_seen++;
        chk("tick", tick, (ncyc % DIV == 0));
        chk("q", q, m_q);
        chk("irq", irq, m_irq());
        chk("tick_b", tick_b, (ncyc % DIV == 0));
        chk("irq_b", irq_b, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int a, input int d);
        addr = 4'(a); di = 8'(d); wren = 1'b1;
        step();
        wren = 1'b0;
    endtask

    task automatic rd(input int a);
        addr = 4'(a); rden = 1'b1;
        step();
        rden = 1'b0;
    endtask

    task automatic wr_b(input int a, input int d);
        addr_b = 4'(a); di_b = 8'(d); wren_b = 1'b1;
        step();
        wren_b = 1'b0;
    endtask

    task automatic rd_b(input string tag, input int a, input int exp);
        addr_b = 4'(a); rden_b = 1'b1;
        step();
        rden_b = 1'b0;
        chk(tag, q_b, exp);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 2 * DIV && (ncyc % DIV) != p; i++) step();
        chk("phase_align", ncyc % DIV, p);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", q, 0);
        chk("rst_tick", tick, 0);
        chk("rst_irq", irq, 0);
        chk("rst_q_b", q_b, 0);
        reset = 1'b0;

        // Idle window: ticks at cycles 10, 20, 30 only.
        idle(35);
        chk("tick_count", tick_seen, 3);

        // Channel 0 one-shot with interrupt.
        wr(0, 8'h03); wr(1, 8'h00); wr(2, 8'h05);
        idle(40);
        rd(0);
        chk("ch0_expired_cnt", q, 0);
        chk("ch0_irq_up", irq, 1);
        wr(2, 8'h85);
        chk("ch0_irq_drop", irq, 0);

        // Channel 1 auto-reload with period 2.
        wr(4, 8'h02); wr(5, 8'h00); wr(6, 8'h03);
        idle(60);
        rd(7);
        chk("reg3_bitmap", q, 8'h02);
        wr(6, 8'h80);

        // Channel 2 coherent 16-bit read across a tick.
        wr(8, 8'h34); wr(9, 8'h12);
        wait_phase(7);
        wr(10, 8'h01);
        rd(8);
        chk("snap_lo", q, 8'h34);
        step();
        rd(9);
        chk("snap_hi", q, 8'h12);
        rd(8);
        chk("after_dec_lo", q, 8'h33);
        wr(10, 8'h00);

        // Commit collides with tick: commit wins.
        wr(0, 8'h05);
        wait_phase(0);
        wr(1, 8'h00);
        rd(0);
        chk("commit_vs_tick", q, 8'h05);
        rd(2);
        chk("commit_no_flag", q, 8'h05);

        // Clear write collides with expiry: set wins.
        wait_phase(7);
        wr(0, 8'h01);
        wr(1, 8'h00);
        step();
        wr(2, 8'h85);
        rd(2);
        chk("set_beats_clear", q, 8'h85);
        chk("set_beats_clear_irq", irq, 1);
        wr(2, 8'h80);

        // NCHAN=3, WIDTH=8 instance.
        wr_b(12, 8'hCD); wr_b(13, 8'hAB); wr_b(14, 8'h07);
        rd_b("b_ch3_reg0", 12, 0);
        rd_b("b_ch3_reg2", 14, 0);
        rd_b("b_ch3_reg3", 15, 0);
        wr_b(0, 8'hCD); wr_b(1, 8'hAB);
        rd_b("b_commit_lo", 0, 8'hCD);
        rd_b("b_commit_hi", 1, 8'h00);
        rd_b("b_ctrl_clean", 2, 8'h00);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int op, ch;
            op = int'($urandom_range(0, 9));
            ch = int'($urandom_range(0, 3));
            case (op)
                0, 1, 2, 3: rd(int'($urandom_range(0, 15)));
                4: wr(ch * 4, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                         : int'($urandom_range(0, 6)));
                5: wr(ch * 4 + 1, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : 0);
                6: wr(ch * 4 + 2, int'($urandom_range(0, 7)) + (($urandom_range(0, 2) == 0) ? 128 : 0));
                7: wr(ch * 4 + 3, int'($urandom_range(0, 255)));
                default: step();
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
